fp_operand_loader: RTL and testbench

Serial-to-parallel operand loader feeding the FP adder datapath. It sits alongside the 8-bit setup register on the same serial configuration/data link. It deserializes two consecutive WORD_W-bit frames from the serial input into operand A and operand B. It then presents both operands to the adder core with a valid/ready handshake.

---
 rtl/fp_operand_loader_if.sv | 36 +++
 rtl/fp_operand_loader.sv | 128 ++++++++++++
 tb/tb_fp_operand_loader.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/fp_operand_loader_if.sv
// Serial operand link and operand-pair handshake between the serial source,
// the operand loader and the FP adder core.
interface fp_operand_loader_if #(
    parameter int WORD_W = 32
);
    logic              en_in;
    logic              serial_in;
    logic              ready_in;
    logic [WORD_W-1:0] op_a_out;
    logic [WORD_W-1:0] op_b_out;
    logic              valid_out;
    logic              busy_out;
    logic              overrun_out;

    modport master (
        output en_in,
        output serial_in,
        output ready_in,
        input  op_a_out,
        input  op_b_out,
        input  valid_out,
        input  busy_out,
        input  overrun_out
    );

    modport slave (
        input  en_in,
        input  serial_in,
        input  ready_in,
        output op_a_out,
        output op_b_out,
        output valid_out,
        output busy_out,
        output overrun_out
    );
endinterface

// File: rtl/fp_operand_loader.sv
// Deserializes two consecutive WORD_W-bit serial frames into operands A and B
// and holds the pair for the adder core until it is accepted.
module fp_operand_loader #(
    parameter int WORD_W    = 32,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk_in,
    input  logic              rst_in,
    fp_operand_loader_if.slave bus
);
    localparam int CNT_W = $clog2(WORD_W);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORD_W - 1);

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [WORD_W-1:0] op_a_q, op_a_d;
    logic [WORD_W-1:0] op_b_q, op_b_d;
    logic              valid_q, valid_d;
    logic              busy_q;
    logic              overrun_q, overrun_d;
    logic [WORD_W-1:0] shifted_s;
    logic              last_bit_s;
    logic              take_bit_s;

    assign last_bit_s = (cnt_q == LAST_IDX);

    // Shift register value with the current serial bit inserted at the chosen end
    always_comb begin
        if (MSB_FIRST) begin
            shifted_s = {shreg_q[WORD_W-2:0], bus.serial_in};
        end else begin
            shifted_s = {bus.serial_in, shreg_q[WORD_W-1:1]};
        end
    end

    // State register
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= LOAD_A;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD_A: begin
                if (bus.en_in && last_bit_s) state_d = LOAD_B;
                else                         state_d = LOAD_A;
            end
            LOAD_B: begin
                if (bus.en_in && last_bit_s) state_d = HOLD;
                else                         state_d = LOAD_B;
            end
            HOLD: begin
                if (bus.ready_in) state_d = LOAD_A;
                else              state_d = HOLD;
            end
            default: state_d = LOAD_A;
        endcase
    end

    // Datapath next values; an accept cycle in HOLD may also start the next frame A
    always_comb begin
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        overrun_d  = overrun_q;
        take_bit_s = 1'b0;
        case (state_q)
            LOAD_A, LOAD_B: take_bit_s = bus.en_in;
            HOLD: begin
                take_bit_s = bus.en_in & bus.ready_in;
                overrun_d  = overrun_q | (bus.en_in & ~bus.ready_in);
            end
            default: take_bit_s = 1'b0;
        endcase
        if (take_bit_s) begin
            shreg_d = shifted_s;
            if (last_bit_s && (state_q != HOLD)) cnt_d = {CNT_W{1'b0}};
            else                                 cnt_d = cnt_q + CNT_W'(1);
            if (last_bit_s && (state_q == LOAD_A)) op_a_d = shifted_s;
            else                                   op_a_d = op_a_q;
            if (last_bit_s && (state_q == LOAD_B)) op_b_d = shifted_s;
            else                                   op_b_d = op_b_q;
        end else begin
            shreg_d = shreg_q;
        end
        valid_d = (state_d == HOLD);
    end

    // Datapath and status registers
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cnt_q     <= {CNT_W{1'b0}};
            shreg_q   <= {WORD_W{1'b0}};
            op_a_q    <= {WORD_W{1'b0}};
            op_b_q    <= {WORD_W{1'b0}};
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            shreg_q   <= shreg_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            valid_q   <= valid_d;
            busy_q    <= (cnt_d != {CNT_W{1'b0}});
            overrun_q <= overrun_d;
        end
    end

    assign bus.op_a_out    = op_a_q;
    assign bus.op_b_out    = op_b_q;
    assign bus.valid_out   = valid_q;
    assign bus.busy_out    = busy_q;
    assign bus.overrun_out = overrun_q;
endmodule

// File: tb/tb_fp_operand_loader.sv
// Drives one serial stream into an MSB-first and an LSB-first loader side by side;
// a reference model queues expected pairs and a monitor compares on every accept.
module tb_fp_operand_loader;
    logic clk = 1'b0;
    logic rst;
    logic en;
    logic serial;
    logic ready;
    int   tests = 0;
    int   failed = 0;

    logic [63:0] q0[$];
    logic [63:0] q1[$];
    logic        held[2];
    logic [63:0] held_v[2];

    fp_operand_loader_if #(.WORD_W(32)) if0();
    fp_operand_loader_if #(.WORD_W(32)) if1();

    assign if0.en_in = en;
    assign if0.serial_in = serial;
    assign if0.ready_in = ready;
    assign if1.en_in = en;
    assign if1.serial_in = serial;
    assign if1.ready_in = ready;

    fp_operand_loader #(.WORD_W(32), .MSB_FIRST(1'b1)) dut0 (
        .clk_in(clk), .rst_in(rst), .bus(if0.slave));
    fp_operand_loader #(.WORD_W(32), .MSB_FIRST(1'b0)) dut1 (
        .clk_in(clk), .rst_in(rst), .bus(if1.slave));

    always #5 clk = ~clk;

    function automatic logic [31:0] rev(input logic [31:0] x);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = x[31-i];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard side: stability while held, and pop/compare on every accept
    task automatic mon(input int ch, input logic v, input logic r,
                       input logic [31:0] a, input logic [31:0] b);
        logic [63:0] e;
        if (v) begin
            if (held[ch]) chk($sformatf("hold_stable%0d", ch), {a, b}, held_v[ch]);
            if (r) begin
                if ((ch == 0 && q0.size() == 0) || (ch == 1 && q1.size() == 0)) begin
                    chk($sformatf("unexpected_valid%0d", ch), 64'd1, 64'd0);
                end else begin
                    e = (ch == 0) ? q0.pop_front() : q1.pop_front();
                    chk($sformatf("pair%0d", ch), {a, b}, e);
                end
                held[ch] = 1'b0;
            end else begin
                held[ch]   = 1'b1;
                held_v[ch] = {a, b};
            end
        end else begin
            held[ch] = 1'b0;
        end
    endtask

    // Monitor: samples outputs on the falling edge
    always @(negedge clk) begin
        if (rst) begin
            held[0] = 1'b0;
            held[1] = 1'b0;
        end else begin
            mon(0, if0.valid_out, ready, if0.op_a_out, if0.op_b_out);
            mon(1, if1.valid_out, ready, if1.op_a_out, if1.op_b_out);
        end
    end

    task automatic step(input logic e, input logic s);
        en = e;
        serial = s;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_busy(input logic exp);
        chk("busy0", {63'd0, if0.busy_out}, {63'd0, exp});
        chk("busy1", {63'd0, if1.busy_out}, {63'd0, exp});
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_ops0"}, {if0.op_a_out, if0.op_b_out}, 64'd0);
        chk({nm, "_ops1"}, {if1.op_a_out, if1.op_b_out}, 64'd0);
        chk({nm, "_flags0"}, {61'd0, if0.valid_out, if0.busy_out, if0.overrun_out}, 64'd0);
        chk({nm, "_flags1"}, {61'd0, if1.valid_out, if1.busy_out, if1.overrun_out}, 64'd0);
    endtask

    // rmode: 0 ready=1, 1 random (1 on first bit), 2 ready=0
    // gmode: 0 none, 1 five idles after bit 13, 2 alternate in B, 3 random idles
    task automatic send_pair(input logic [31:0] a, input logic [31:0] b,
                             input int rmode, input int gmode, input int abort_after);
        logic [63:0] stream;
        stream = {a, b};
        if (abort_after == 0) begin
            q0.push_back({a, b});
            q1.push_back({rev(a), rev(b)});
        end
        for (int i = 0; i < 64; i++) begin
            if (abort_after != 0 && i >= abort_after) return;
            if (rmode == 0)      ready = 1'b1;
            else if (rmode == 2) ready = 1'b0;
            else if (i == 0)     ready = 1'b1;
            else                 ready = 1'($urandom);
            if (i == 63) begin
                en = 1'b1;
                serial = stream[0];
                @(negedge clk);
                chk("valid_early0", {63'd0, if0.valid_out}, 64'd0);
                chk("valid_early1", {63'd0, if1.valid_out}, 64'd0);
                @(posedge clk);
                #1;
                chk("valid_rise0", {63'd0, if0.valid_out}, 64'd1);
                chk("valid_rise1", {63'd0, if1.valid_out}, 64'd1);
                chk_busy(1'b0);
            end else begin
                step(1'b1, stream[63-i]);
                chk_busy(((i + 1) % 32) != 0);
                if (gmode == 1 && i == 13) begin
                    repeat (5) begin
                        step(1'b0, 1'($urandom));
                        chk_busy(1'b1);
                    end
                end
                if (gmode == 2 && i >= 32) begin
                    step(1'b0, 1'($urandom));
                    chk_busy(1'b1);
                end
                if (gmode == 3 && $urandom_range(0, 3) == 0) begin
                    repeat ($urandom_range(1, 3)) begin
                        step(1'b0, 1'($urandom));
                        chk_busy(((i + 1) % 32) != 0);
                    end
                end
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        held[0] = 1'b0;
        held[1] = 1'b0;
        rst = 1'b1;
        en = 1'b0;
        serial = 1'b0;
        ready = 1'b0;
        @(posedge clk);
        #1;
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) step(1'b0, 1'(k));
        chk_zero("reset_idle");

        // Basic pair, continuous strobes, accepted immediately
        send_pair(32'h3F80_0000, 32'h4000_0000, 0, 0, 0);
        chk("basic_ops0", {if0.op_a_out, if0.op_b_out}, {32'h3F80_0000, 32'h4000_0000});
        step(1'b0, 1'b0);
        chk("basic_fall0", {63'd0, if0.valid_out}, 64'd0);
        chk("basic_fall1", {63'd0, if1.valid_out}, 64'd0);

        // Gapped strobes
        send_pair(32'h4049_0FDB, 32'hBF80_0000, 0, 1, 0);
        step(1'b0, 1'b0);
        send_pair(32'h4049_0FDB, 32'hBF80_0000, 0, 2, 0);
        step(1'b0, 1'b0);

        // Random pairs with random ready, gaps and hold time
        for (int n = 0; n < 12; n++) begin
            send_pair($urandom, $urandom, 1, 3, 0);
            repeat ($urandom_range(0, 3)) begin
                ready = 1'b0;
                step(1'b0, 1'($urandom));
            end
        end
        ready = 1'b1;
        step(1'b0, 1'b0);
        chk("no_overrun0", {63'd0, if0.overrun_out}, 64'd0);
        chk("no_overrun1", {63'd0, if1.overrun_out}, 64'd0);

        // Back-to-back zero-bubble pairs, values chosen for the LSB-first loader
        send_pair(rev(32'h0000_0001), rev(32'h8000_0000), 0, 0, 0);
        send_pair(rev(32'hFFFF_FFFF), rev(32'h0000_FFFF), 0, 0, 0);
        chk("b2b_ops1", {if1.op_a_out, if1.op_b_out}, {32'hFFFF_FFFF, 32'h0000_FFFF});
        step(1'b0, 1'b0);

        // Backpressure with strobes arriving while held
        send_pair(32'hC049_0FDB, 32'h0000_0001, 2, 0, 0);
        for (int c = 0; c < 10; c++) step((c == 1 || c == 4 || c == 7), 1'($urandom));
        chk("bp_valid0", {63'd0, if0.valid_out}, 64'd1);
        chk("bp_ops0", {if0.op_a_out, if0.op_b_out}, {32'hC049_0FDB, 32'h0000_0001});
        chk("bp_overrun0", {63'd0, if0.overrun_out}, 64'd1);
        chk("bp_overrun1", {63'd0, if1.overrun_out}, 64'd1);
        chk_busy(1'b0);
        ready = 1'b1;
        step(1'b0, 1'b0);
        chk("bp_fall0", {63'd0, if0.valid_out}, 64'd0);
        step(1'b0, 1'b0);
        chk("sticky0", {63'd0, if0.overrun_out}, 64'd1);
        chk("sticky1", {63'd0, if1.overrun_out}, 64'd1);

        // Reset inside frame B, then a fresh pair
        chk("queue_idle0", 64'(q0.size()), 64'd0);
        send_pair(32'hAAAA_5555, 32'h0F0F_0F0F, 0, 0, 40);
        rst = 1'b1;
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        rst = 1'b0;
        chk_zero("reset_mid");
        send_pair(32'h1234_5678, 32'h9ABC_DEF0, 0, 0, 0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);

        chk("drain0", 64'(q0.size()), 64'd0);
        chk("drain1", 64'(q1.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
